mem_master: RTL and testbench

Bus initiator for the 32-bit instruction/data memory. It accepts single-word read or write requests from the CPU datapath over a valid/ready handshake, drives the memory's `addr`/`read`/`write`/`datain` lines for a programmable number of wait cycles, and captures `dataout`. It returns one response pulse per request. Misaligned requests are rejected without touching memory.

---
 rtl/mem_master_if.sv | 33 +++
 rtl/mem_master.sv | 111 +++++++++++
 tb/tb_mem_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_master_if.sv
// mem_master_if: request/response handshake plus memory bus for mem_master.
//   CPU side : req_valid, req_write, req_addr, req_wdata -> req_ready,
//              resp_valid, resp_err, resp_rdata
//   Memory   : addr, read, write, datain -> dataout
// modport master is the initiator (mem_master). modport slave is the
// opposite view, used by whatever sits around it (CPU plus memory).
interface mem_master_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [31:0] datain;
    logic [31:0] dataout;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, dataout,
        output req_ready, resp_valid, resp_err, resp_rdata,
               addr, read, write, datain
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, dataout,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               addr, read, write, datain
    );
endinterface

// File: rtl/mem_master.sv
// mem_master: single-word bus initiator for the 32-bit instruction/data memory.
// Takes one read or write request at a time from the CPU. It holds the memory
// strobe for WAIT_CYCLES extra cycles, then returns one response pulse.
// Misaligned requests get an error response and make no memory access.
// Ports:
//   CLK          clock, all state changes on posedge
//   RST          synchronous active-high reset
//   bus.master   request/response handshake and memory bus (mem_master_if)
// Parameters:
//   WAIT_CYCLES  extra strobe cycles before sampling memory, 0..15
//
// state  | meaning
// IDLE   | ready for a request, strobes low
// ACCESS | memory strobe phase, wait counter running down
// RESP   | successful response pulse
// ERR    | misaligned-request error pulse, no memory access made
module mem_master #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic         CLK,
    input  logic         RST,
    mem_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_write_q, op_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] datain_q, datain_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        datain_d   = datain_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_addr[1:0] != 2'b00) begin
                        // Rejected before touching memory, so addr/datain keep their old values.
                        state_d = ERR;
                    end else begin
                        addr_d     = bus.req_addr;
                        op_write_d = bus.req_write;
                        if (bus.req_write) begin
                            datain_d = bus.req_wdata;
                        end
                        cnt_d   = WAIT_INIT;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (!op_write_q) begin
                        rdata_d = bus.dataout;
                    end
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= 32'd0;
            datain_q   <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            datain_q   <= datain_d;
            rdata_q    <= rdata_d;
        end
    end

    // Reads strobe for the whole access window. Writes strobe only in the
    // last cycle, so each request makes exactly one memory write.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.read       = (state_q == ACCESS) && !op_write_q;
    assign bus.write      = (state_q == ACCESS) && op_write_q && (cnt_q == 4'd0);
    assign bus.resp_valid = (state_q == RESP) || (state_q == ERR);
    assign bus.resp_err   = (state_q == ERR);
    assign bus.addr       = addr_q;
    assign bus.datain     = datain_q;
    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

    localparam int W = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_master_if bus();

    mem_master #(.WAIT_CYCLES(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00: rom = 32'h00000820;
            32'h04: rom = 32'h2003000A;
            32'h08: rom = 32'h00001020;
            32'h0C: rom = 32'h20420001;
            32'h10: rom = 32'h00220820;
            32'h14: rom = 32'h1443FFFD;
            32'h18: rom = 32'h1000FFFF;
            default: rom = 32'h00000000;
        endcase
    endfunction

    // Memory model: combinational read, junk when not strobed.
    assign bus.dataout = bus.read ? rom(bus.addr) : 32'hBAD0BAD0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          read_cnt = 0;
    int          write_cnt = 0;
    int          resp_cnt = 0;
    int          acc_cyc = 0;
    int          resp_cyc = 0;
    int          acc_times[$];
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] model_rdata = 32'd0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.read && bus.write) begin
            errors++;
            $display("FAIL strobe_overlap read=%0b write=%0b required not both", bus.read, bus.write);
        end
        if (bus.read) read_cnt++;
        if (bus.write) begin
            write_cnt++;
            wr_addr = bus.addr;
            wr_data = bus.datain;
        end
        if (!RST && bus.req_valid && bus.req_ready) begin
            acc_cyc = cyc;
            acc_times.push_back(cyc);
        end
        if (bus.resp_valid) begin
            resp_cnt++;
            resp_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected resp_valid=1 at cycle %0d required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.resp_err !== mon_e.err || bus.resp_rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL resp_data err=%0b rdata=%08h required err=%0b rdata=%08h",
                             bus.resp_err, bus.resp_rdata, mon_e.err, mon_e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit track);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 50) begin
            checks++; errors++;
            $display("FAIL issue_ready_timeout req_ready=%0b required 1", bus.req_ready);
        end
        if (track) begin
            e.err = (a[1:0] != 2'b00);
            if (!e.err && !wr) model_rdata = rom(a);
            e.rdata = model_rdata;
            exp_q.push_back(e);
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int k;
        k = 0;
        while (resp_cnt < target && k < 100) begin
            @(posedge CLK); #1;
            k++;
        end
        checks++;
        if (resp_cnt < target) begin
            errors++;
            $display("FAIL resp_timeout responses=%0d required %0d", resp_cnt, target);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            checks++;
            if ({bus.read, bus.write, bus.resp_valid} !== 3'b000) begin
                errors++;
                $display("FAIL reset_quiet read=%0b write=%0b resp_valid=%0b required 0",
                         bus.read, bus.write, bus.resp_valid);
            end
        end
        RST = 1'b0;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.addr !== 32'd0 || bus.datain !== 32'd0 || bus.resp_rdata !== 32'd0 ||
            bus.resp_err !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values addr=%08h datain=%08h rdata=%08h err=%0b valid=%0b ready=%0b required 0/0/0/0/0/1",
                     bus.addr, bus.datain, bus.resp_rdata, bus.resp_err, bus.resp_valid, bus.req_ready);
        end
        repeat (3) begin @(posedge CLK); #1; end
        checks++;
        if (resp_cnt !== 0 || read_cnt !== 0 || write_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_activity resp=%0d reads=%0d writes=%0d required 0",
                     resp_cnt, read_cnt, write_cnt);
        end
    endtask

    task automatic test_single_read();
        int r0, n;
        r0 = read_cnt; n = resp_cnt;
        issue(1'b0, 32'h0, 32'h0, 1'b1);
        wait_resp(n + 1);
        checks++;
        if (read_cnt - r0 !== W + 1) begin
            errors++;
            $display("FAIL read_strobe_len cycles=%0d required %0d", read_cnt - r0, W + 1);
        end
        checks++;
        if (resp_cyc - acc_cyc !== W + 2) begin
            errors++;
            $display("FAIL read_latency cycles=%0d required %0d", resp_cyc - acc_cyc, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        int n, k;
        acc_times.delete();
        n = resp_cnt;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            bus.req_addr = 32'(i * 4);
            e.err = 1'b0;
            model_rdata = rom(32'(i * 4));
            e.rdata = model_rdata;
            exp_q.push_back(e);
            k = 0;
            while (!bus.req_ready && k < 50) begin
                @(posedge CLK); #1;
                k++;
            end
            if (k >= 50) begin
                checks++; errors++;
                $display("FAIL b2b_ready_timeout req_ready=%0b required 1", bus.req_ready);
            end
            @(posedge CLK); #1;
        end
        bus.req_valid = 1'b0;
        wait_resp(n + 7);
        checks++;
        if (acc_times.size() !== 7) begin
            errors++;
            $display("FAIL b2b_accepts count=%0d required 7", acc_times.size());
        end else begin
            for (int i = 1; i < 7; i++) begin
                checks++;
                if (acc_times[i] - acc_times[i-1] !== W + 3) begin
                    errors++;
                    $display("FAIL b2b_spacing gap=%0d required %0d", acc_times[i] - acc_times[i-1], W + 3);
                end
            end
        end
    endtask

    task automatic test_write();
        int w0, r0, n;
        w0 = write_cnt; r0 = read_cnt; n = resp_cnt;
        issue(1'b1, 32'h30, 32'hDEADBEEF, 1'b1);
        wait_resp(n + 1);
        checks++;
        if (write_cnt - w0 !== 1 || read_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL write_strobe writes=%0d reads=%0d required 1/0", write_cnt - w0, read_cnt - r0);
        end
        checks++;
        if (wr_addr !== 32'h30 || wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_bus addr=%08h data=%08h required 00000030/deadbeef", wr_addr, wr_data);
        end
        checks++;
        if (resp_cyc - acc_cyc !== W + 2) begin
            errors++;
            $display("FAIL write_latency cycles=%0d required %0d", resp_cyc - acc_cyc, W + 2);
        end
    endtask

    task automatic test_misaligned();
        int w0, r0, n;
        w0 = write_cnt; r0 = read_cnt; n = resp_cnt;
        issue(1'b0, 32'h2, 32'h0, 1'b1);
        wait_resp(n + 1);
        checks++;
        if (write_cnt - w0 !== 0 || read_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL misaligned_strobe writes=%0d reads=%0d required 0/0", write_cnt - w0, read_cnt - r0);
        end
        checks++;
        if (resp_cyc - acc_cyc !== 1) begin
            errors++;
            $display("FAIL misaligned_latency cycles=%0d required 1", resp_cyc - acc_cyc);
        end
        checks++;
        if (bus.addr !== 32'h30 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_after addr=%08h ready=%0b required 00000030/1", bus.addr, bus.req_ready);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        n = resp_cnt;
        issue(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge CLK); #1;
        checks++;
        if (bus.read !== 1'b1) begin
            errors++;
            $display("FAIL midrst_access read=%0b required 1", bus.read);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_rdata = 32'd0;
        checks++;
        if (bus.read !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop read=%0b required 0", bus.read);
        end
        repeat (5) begin @(posedge CLK); #1; end
        checks++;
        if (resp_cnt !== n || bus.resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL midrst_no_resp responses=%0d rdata=%08h required %0d/00000000",
                     resp_cnt, bus.resp_rdata, n);
        end
        issue(1'b0, 32'h4, 32'h0, 1'b1);
        wait_resp(n + 1);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_misaligned();
        test_mid_reset();
        repeat (4) begin @(posedge CLK); #1; end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
